// File: rtl/cu_pkg.sv
// Shared definitions for the compute-unit issue stage: unit codes,
// condition codes, instruction field positions, ASTAT bit indices and
// the one-hot compute writeback selects.
package cu_pkg;

   // Execution unit codes (instr[31:30])
   localparam logic [1:0] UNIT_NOP = 2'b00;
   localparam logic [1:0] UNIT_ALU = 2'b01;
   localparam logic [1:0] UNIT_MUL = 2'b10;
   localparam logic [1:0] UNIT_SHF = 2'b11;

   // Condition codes; 12..14 are never true
   localparam logic [3:0] COND_EQ    = 4'd0;
   localparam logic [3:0] COND_NE    = 4'd1;
   localparam logic [3:0] COND_LT    = 4'd2;
   localparam logic [3:0] COND_GE    = 4'd3;
   localparam logic [3:0] COND_AC    = 4'd4;
   localparam logic [3:0] COND_NAC   = 4'd5;
   localparam logic [3:0] COND_AV    = 4'd6;
   localparam logic [3:0] COND_MV    = 4'd7;
   localparam logic [3:0] COND_MN    = 4'd8;
   localparam logic [3:0] COND_SV    = 4'd9;
   localparam logic [3:0] COND_SZ    = 4'd10;
   localparam logic [3:0] COND_COMPD = 4'd11;
   localparam logic [3:0] COND_TRUE  = 4'd15;

   // Instruction field bit positions
   localparam int F_UNIT_HI = 31;
   localparam int F_UNIT_LO = 30;
   localparam int F_COND_EN = 29;
   localparam int F_COND_HI = 28;
   localparam int F_COND_LO = 25;
   localparam int F_OP_HI   = 24;
   localparam int F_OP_LO   = 16;
   localparam int F_RSV_HI  = 15;
   localparam int F_RSV_LO  = 12;
   localparam int F_RN_HI   = 11;
   localparam int F_RN_LO   = 8;
   localparam int F_RX_HI   = 7;
   localparam int F_RX_LO   = 4;
   localparam int F_RY_HI   = 3;
   localparam int F_RY_LO   = 0;

   // ALU half-cycle code that marks a compare (no register writeback)
   localparam logic [1:0] HC_CMP = 2'b11;

   // ASTAT bit indices; the low FLAG_W bits are the live flags, the top
   // three are sticky overflow bits
   localparam int A_AZ    = 0;
   localparam int A_AN    = 1;
   localparam int A_AC    = 2;
   localparam int A_AV    = 3;
   localparam int A_MV    = 4;
   localparam int A_MN    = 5;
   localparam int A_SV    = 6;
   localparam int A_SZ    = 7;
   localparam int A_COMPD = 8;
   localparam int A_AVS   = 9;
   localparam int A_MVS   = 10;
   localparam int A_SVS   = 11;
   localparam int FLAG_W  = 9;
   localparam int ASTAT_W = 12;

   // Compute writeback selects, one-hot per unit
   localparam logic [2:0] CUEN_NONE = 3'b000;
   localparam logic [2:0] CUEN_ALU  = 3'b001;
   localparam logic [2:0] CUEN_MUL  = 3'b010;
   localparam logic [2:0] CUEN_SHF  = 3'b100;

   // Map a unit code to its writeback select
   function automatic logic [2:0] unit_cuen(input logic [1:0] unit);
      logic [2:0] sel;
      case (unit)
         UNIT_ALU: sel = CUEN_ALU;
         UNIT_MUL: sel = CUEN_MUL;
         UNIT_SHF: sel = CUEN_SHF;
         default:  sel = CUEN_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/cu_cond_eval.sv
// Combinational condition-code evaluation against the live ASTAT flags.
// A disabled condition always evaluates true.
module cu_cond_eval
   import cu_pkg::*;
(
   input  logic [FLAG_W-1:0] flags,
   input  logic [3:0]        cond,
   input  logic              cond_en,
   output logic              cond_true
);

   logic code_true;

   // Select the flag (or its inverse) named by the condition code
   always_comb begin
      code_true = 1'b0;
      case (cond)
         COND_EQ:    code_true = flags[A_AZ];
         COND_NE:    code_true = ~flags[A_AZ];
         COND_LT:    code_true = flags[A_AN];
         COND_GE:    code_true = ~flags[A_AN];
         COND_AC:    code_true = flags[A_AC];
         COND_NAC:   code_true = ~flags[A_AC];
         COND_AV:    code_true = flags[A_AV];
         COND_MV:    code_true = flags[A_MV];
         COND_MN:    code_true = flags[A_MN];
         COND_SV:    code_true = flags[A_SV];
         COND_SZ:    code_true = flags[A_SZ];
         COND_COMPD: code_true = flags[A_COMPD];
         COND_TRUE:  code_true = 1'b1;
         default:    code_true = 1'b0;
      endcase
   end

   assign cond_true = ~cond_en | code_true;

endmodule

// File: rtl/cu_issue.sv
// Compute-unit issue stage. An instruction captured at a rising edge
// drives read addresses and unit controls for one cycle (stage I), then
// sequences register-file writeback and flag capture the next cycle
// (stage W). Conditions are checked at capture against the ASTAT value
// that the same edge will write, so flags returned by the instruction
// currently in W are visible without a bubble.
module cu_issue
   import cu_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 4,
   parameter int SIGNAL_WIDTH  = 3,
   parameter int INSTR_WIDTH   = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     stall,
   input  logic                     instr_valid,
   input  logic [INSTR_WIDTH-1:0]   instr,
   input  logic                     astat_clr,
   input  logic                     bc_wr_en,
   input  logic [ADDRESS_WIDTH-1:0] bc_wr_add,
   output logic                     bc_ready,
   output logic [ADDRESS_WIDTH-1:0] ps_xb_raddx,
   output logic [ADDRESS_WIDTH-1:0] ps_xb_raddy,
   output logic [ADDRESS_WIDTH-1:0] ps_xb_wadd,
   output logic [SIGNAL_WIDTH-1:0]  ps_xb_w_cuEn,
   output logic                     ps_xb_w_bcEn,
   output logic                     ps_alu_en,
   output logic                     ps_alu_log,
   output logic [1:0]               ps_alu_hc,
   output logic [2:0]               ps_alu_sc,
   output logic                     ps_alu_sat,
   output logic                     ps_alu_ci,
   output logic                     ps_mul_en,
   output logic                     ps_mul_otreg,
   output logic [3:0]               ps_mul_dtsts,
   output logic [1:0]               ps_mul_cls,
   output logic [1:0]               ps_mul_sc,
   output logic                     ps_shf_en,
   output logic [1:0]               ps_shf_cls,
   input  logic                     alu_ps_az,
   input  logic                     alu_ps_an,
   input  logic                     alu_ps_ac,
   input  logic                     alu_ps_av,
   input  logic                     alu_ps_compd,
   input  logic                     mul_ps_mv,
   input  logic                     mul_ps_mn,
   input  logic                     shf_ps_sv,
   input  logic                     shf_ps_sz,
   output logic [ASTAT_W-1:0]       astat
);

   // Stage I registers
   logic                     vld_p1;
   logic [1:0]               unit_p1;
   logic [8:0]               op_p1;
   logic [ADDRESS_WIDTH-1:0] rn_p1;
   logic [ADDRESS_WIDTH-1:0] rx_p1;
   logic [ADDRESS_WIDTH-1:0] ry_p1;

   // Stage W registers
   logic                     vld_p2;
   logic [1:0]               unit_p2;
   logic [ADDRESS_WIDTH-1:0] rn_p2;
   logic                     cmp_p2;

   logic [ASTAT_W-1:0]       astat_q;
   logic [ASTAT_W-1:0]       astat_nxt;
   logic                     cond_true;
   logic                     issue_ok;
   logic [2:0]               cuen_p2;
   logic                     bc_acc;
   logic                     unused_rsvd;

   // Reserved instruction bits carry no function
   assign unused_rsvd = ^instr[F_RSV_HI:F_RSV_LO];

   cu_cond_eval u_cond (
      .flags     (astat_nxt[FLAG_W-1:0]),
      .cond      (instr[F_COND_HI:F_COND_LO]),
      .cond_en   (instr[F_COND_EN]),
      .cond_true (cond_true)
   );

   // A nop or a failed condition never enters the pipe as a live op
   assign issue_ok = instr_valid & (instr[F_UNIT_HI:F_UNIT_LO] != UNIT_NOP) & cond_true;

   // ---- capture -> stage I ----
   // Capture the decoded fields; bubbles load zeros so idle outputs read 0
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1  <= 1'b0;
         unit_p1 <= UNIT_NOP;
         op_p1   <= '0;
         rn_p1   <= '0;
         rx_p1   <= '0;
         ry_p1   <= '0;
      end else if (!stall) begin
         vld_p1 <= issue_ok;
         if (issue_ok) begin
            unit_p1 <= instr[F_UNIT_HI:F_UNIT_LO];
            op_p1   <= instr[F_OP_HI:F_OP_LO];
            rn_p1   <= instr[F_RN_HI:F_RN_LO];
            rx_p1   <= instr[F_RX_HI:F_RX_LO];
            ry_p1   <= instr[F_RY_HI:F_RY_LO];
         end else begin
            unit_p1 <= UNIT_NOP;
            op_p1   <= '0;
            rn_p1   <= '0;
            rx_p1   <= '0;
            ry_p1   <= '0;
         end
      end
   end

   assign ps_alu_en = vld_p1 & (unit_p1 == UNIT_ALU);
   assign ps_mul_en = vld_p1 & (unit_p1 == UNIT_MUL);
   assign ps_shf_en = vld_p1 & (unit_p1 == UNIT_SHF);

   assign ps_xb_raddx = rx_p1;
   assign ps_xb_raddy = ry_p1;

   // Each unit only sees its own op bits; other units' controls stay low
   assign ps_alu_log   = ps_alu_en & op_p1[8];
   assign ps_alu_hc    = ps_alu_en ? op_p1[7:6] : 2'b00;
   assign ps_alu_sc    = ps_alu_en ? op_p1[5:3] : 3'b000;
   assign ps_alu_sat   = ps_alu_en & op_p1[2];
   assign ps_alu_ci    = ps_alu_en & op_p1[1];

   assign ps_mul_otreg = ps_mul_en & op_p1[8];
   assign ps_mul_dtsts = ps_mul_en ? op_p1[7:4] : 4'b0000;
   assign ps_mul_cls   = ps_mul_en ? op_p1[3:2] : 2'b00;
   assign ps_mul_sc    = ps_mul_en ? op_p1[1:0] : 2'b00;

   assign ps_shf_cls   = ps_shf_en ? op_p1[1:0] : 2'b00;

   // ---- stage I -> stage W ----
   // Advance the writeback descriptor; compares are tagged to suppress writeback
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p2  <= 1'b0;
         unit_p2 <= UNIT_NOP;
         rn_p2   <= '0;
         cmp_p2  <= 1'b0;
      end else if (!stall) begin
         vld_p2  <= vld_p1;
         unit_p2 <= unit_p1;
         rn_p2   <= rn_p1;
         cmp_p2  <= (unit_p1 == UNIT_ALU) && (op_p1[7:6] == HC_CMP);
      end
   end

   assign cuen_p2 = (vld_p2 && !cmp_p2) ? unit_cuen(unit_p2) : CUEN_NONE;

   // The bus may use the write port whenever no compute result owns it
   assign bc_ready     = ~(vld_p2 & (cuen_p2 != CUEN_NONE));
   assign bc_acc       = bc_wr_en & bc_ready;
   assign ps_xb_w_bcEn = bc_acc;
   assign ps_xb_w_cuEn = cuen_p2;
   assign ps_xb_wadd   = bc_acc ? bc_wr_add : rn_p2;

   // Next ASTAT: executing unit's flags replace the old ones, sticky bits
   // accumulate, and a sticky set in the same cycle overrides a clear
   always_comb begin
      astat_nxt = astat_q;
      if (!stall) begin
         if (astat_clr) begin
            astat_nxt[A_AVS] = 1'b0;
            astat_nxt[A_MVS] = 1'b0;
            astat_nxt[A_SVS] = 1'b0;
         end
         if (vld_p2) begin
            case (unit_p2)
               UNIT_ALU: begin
                  astat_nxt[A_AZ]    = alu_ps_az;
                  astat_nxt[A_AN]    = alu_ps_an;
                  astat_nxt[A_AC]    = alu_ps_ac;
                  astat_nxt[A_AV]    = alu_ps_av;
                  astat_nxt[A_COMPD] = alu_ps_compd;
                  astat_nxt[A_AVS]   = astat_nxt[A_AVS] | alu_ps_av;
               end
               UNIT_MUL: begin
                  astat_nxt[A_MV]  = mul_ps_mv;
                  astat_nxt[A_MN]  = mul_ps_mn;
                  astat_nxt[A_MVS] = astat_nxt[A_MVS] | mul_ps_mv;
               end
               UNIT_SHF: begin
                  astat_nxt[A_SV]  = shf_ps_sv;
                  astat_nxt[A_SZ]  = shf_ps_sz;
                  astat_nxt[A_SVS] = astat_nxt[A_SVS] | shf_ps_sv;
               end
               default: ;
            endcase
         end
      end
   end

   // ---- stage W flag capture ----
   // Register the status word (astat_nxt already holds under stall)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         astat_q <= '0;
      end else begin
         astat_q <= astat_nxt;
      end
   end

   assign astat = astat_q;

endmodule

// File: tb/tb_cu_issue.sv
// Directed bench for cu_issue: stimulus pushes expected stage-I and
// stage-W responses into queues; a negedge monitor pops and compares
// whenever the DUT presents a unit enable or a writeback.
module tb_cu_issue;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        instr_valid;
   logic [31:0] instr;
   logic        astat_clr;
   logic        bc_wr_en;
   logic [3:0]  bc_wr_add;
   logic        bc_ready;
   logic [3:0]  ps_xb_raddx, ps_xb_raddy, ps_xb_wadd;
   logic [2:0]  ps_xb_w_cuEn;
   logic        ps_xb_w_bcEn;
   logic        ps_alu_en, ps_alu_log, ps_alu_sat, ps_alu_ci;
   logic [1:0]  ps_alu_hc;
   logic [2:0]  ps_alu_sc;
   logic        ps_mul_en, ps_mul_otreg;
   logic [3:0]  ps_mul_dtsts;
   logic [1:0]  ps_mul_cls, ps_mul_sc;
   logic        ps_shf_en;
   logic [1:0]  ps_shf_cls;
   logic        alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av, alu_ps_compd;
   logic        mul_ps_mv, mul_ps_mn, shf_ps_sv, shf_ps_sz;
   logic [11:0] astat;

   int total = 0;
   int bad   = 0;

   logic [29:0] iss_q[$];
   logic [7:0]  wb_q[$];

   cu_issue dut (
      .clk(clk), .reset(reset), .stall(stall),
      .instr_valid(instr_valid), .instr(instr), .astat_clr(astat_clr),
      .bc_wr_en(bc_wr_en), .bc_wr_add(bc_wr_add), .bc_ready(bc_ready),
      .ps_xb_raddx(ps_xb_raddx), .ps_xb_raddy(ps_xb_raddy),
      .ps_xb_wadd(ps_xb_wadd), .ps_xb_w_cuEn(ps_xb_w_cuEn),
      .ps_xb_w_bcEn(ps_xb_w_bcEn),
      .ps_alu_en(ps_alu_en), .ps_alu_log(ps_alu_log), .ps_alu_hc(ps_alu_hc),
      .ps_alu_sc(ps_alu_sc), .ps_alu_sat(ps_alu_sat), .ps_alu_ci(ps_alu_ci),
      .ps_mul_en(ps_mul_en), .ps_mul_otreg(ps_mul_otreg),
      .ps_mul_dtsts(ps_mul_dtsts), .ps_mul_cls(ps_mul_cls), .ps_mul_sc(ps_mul_sc),
      .ps_shf_en(ps_shf_en), .ps_shf_cls(ps_shf_cls),
      .alu_ps_az(alu_ps_az), .alu_ps_an(alu_ps_an), .alu_ps_ac(alu_ps_ac),
      .alu_ps_av(alu_ps_av), .alu_ps_compd(alu_ps_compd),
      .mul_ps_mv(mul_ps_mv), .mul_ps_mn(mul_ps_mn),
      .shf_ps_sv(shf_ps_sv), .shf_ps_sz(shf_ps_sz),
      .astat(astat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction word from its fields
   function automatic logic [31:0] mk(input logic [1:0] u, input logic ce,
                                      input logic [3:0] c, input logic [8:0] op,
                                      input logic [3:0] rn, input logic [3:0] rx,
                                      input logic [3:0] ry);
      return {u, ce, c, op, 4'h0, rn, rx, ry};
   endfunction

   // Expected stage-I view: {shf,mul,alu enables, raddx, raddy, alu ctl, mul ctl, shf cls}
   function automatic logic [29:0] iv(input logic [2:0] en, input logic [3:0] rx,
                                      input logic [3:0] ry, input logic [7:0] a,
                                      input logic [8:0] m, input logic [1:0] s);
      return {en, rx, ry, a, m, s};
   endfunction

   // Expected stage-W view: {cuEn, wadd, bcEn}
   function automatic logic [7:0] wv(input logic [2:0] cu, input logic [3:0] wa,
                                     input logic bc);
      return {cu, wa, bc};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_flags();
      alu_ps_az = 0; alu_ps_an = 0; alu_ps_ac = 0; alu_ps_av = 0; alu_ps_compd = 0;
      mul_ps_mv = 0; mul_ps_mn = 0; shf_ps_sv = 0; shf_ps_sz = 0;
   endtask

   // Present one instruction for a single capture edge
   task automatic issue(input logic [31:0] w);
      instr_valid = 1'b1;
      instr       = w;
      tick();
      instr_valid = 1'b0;
      instr       = '0;
   endtask

   logic [29:0] act_iss, exp_iss;
   logic [7:0]  act_wb, exp_wb;

   // Monitor: one event per presentation that the pipe moves past
   always @(negedge clk) begin
      if (reset && !stall) begin
         act_iss = {ps_shf_en, ps_mul_en, ps_alu_en, ps_xb_raddx, ps_xb_raddy,
                    ps_alu_log, ps_alu_hc, ps_alu_sc, ps_alu_sat, ps_alu_ci,
                    ps_mul_otreg, ps_mul_dtsts, ps_mul_cls, ps_mul_sc, ps_shf_cls};
         act_wb  = {ps_xb_w_cuEn, ps_xb_wadd, ps_xb_w_bcEn};
         if (ps_alu_en || ps_mul_en || ps_shf_en) begin
            total++;
            if (iss_q.size() == 0) begin
               bad++;
               $display("FAIL issue_unexpected actual=%h required=none", act_iss);
            end else begin
               exp_iss = iss_q.pop_front();
               if (act_iss !== exp_iss) begin
                  bad++;
                  $display("FAIL issue_view actual=%h required=%h", act_iss, exp_iss);
               end
            end
         end
         if (ps_xb_w_cuEn != 3'b000 || ps_xb_w_bcEn) begin
            total++;
            if (wb_q.size() == 0) begin
               bad++;
               $display("FAIL wb_unexpected actual=%h required=none", act_wb);
            end else begin
               exp_wb = wb_q.pop_front();
               if (act_wb !== exp_wb) begin
                  bad++;
                  $display("FAIL wb_view actual=%h required=%h", act_wb, exp_wb);
               end
            end
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 0; stall = 0; instr_valid = 0; instr = 0; astat_clr = 0;
      bc_wr_en = 0; bc_wr_add = 0;
      clr_flags();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_astat", astat, 12'h000);
      chk("rst_bc_ready", bc_ready, 1);
      chk("rst_cuen", ps_xb_w_cuEn, 0);
      chk("rst_en", {ps_shf_en, ps_mul_en, ps_alu_en}, 0);
      reset = 1;
      tick();

      // ALU add, az returned in W
      iss_q.push_back(iv(3'b001, 4'd1, 4'd2, 8'h00, 9'h000, 2'b00));
      wb_q.push_back(wv(3'b001, 4'd4, 1'b0));
      issue(mk(2'b01, 1'b0, 4'd0, 9'h000, 4'd4, 4'd1, 4'd2));
      tick();
      alu_ps_az = 1;
      tick();
      clr_flags();
      chk("t1_astat", astat, 12'h001);

      // MUL sets mv; conditional ALU (MV) issues
      iss_q.push_back(iv(3'b010, 4'd6, 4'd7, 8'h00, 9'h1A7, 2'b00));
      wb_q.push_back(wv(3'b010, 4'd5, 1'b0));
      iss_q.push_back(iv(3'b001, 4'd3, 4'd9, 8'hD7, 9'h000, 2'b00));
      wb_q.push_back(wv(3'b001, 4'd8, 1'b0));
      issue(mk(2'b10, 1'b0, 4'd0, 9'h1A7, 4'd5, 4'd6, 4'd7));
      tick();
      mul_ps_mv   = 1;
      instr_valid = 1;
      instr       = mk(2'b01, 1'b1, 4'd7, 9'h1AE, 4'd8, 4'd3, 4'd9);
      tick();
      instr_valid = 0;
      instr       = 0;
      clr_flags();
      chk("t2_astat_mv", astat, 12'h411);
      tick();
      tick();
      chk("t2_astat_after_alu", astat, 12'h410);

      // MUL clears mv; the same conditional ALU is squashed
      iss_q.push_back(iv(3'b010, 4'd2, 4'd3, 8'h00, 9'h000, 2'b00));
      wb_q.push_back(wv(3'b010, 4'd1, 1'b0));
      issue(mk(2'b10, 1'b0, 4'd0, 9'h000, 4'd1, 4'd2, 4'd3));
      tick();
      instr_valid = 1;
      instr       = mk(2'b01, 1'b1, 4'd7, 9'h1AE, 4'd8, 4'd3, 4'd9);
      tick();
      instr_valid = 0;
      instr       = 0;
      chk("t2b_squash_en", {ps_shf_en, ps_mul_en, ps_alu_en}, 0);
      chk("t2b_astat", astat, 12'h400);
      tick();
      chk("t2b_squash_cuen", ps_xb_w_cuEn, 0);
      chk("t2b_bc_ready", bc_ready, 1);

      // Compare: no writeback, flags captured, sticky clear
      iss_q.push_back(iv(3'b001, 4'd4, 4'd5, 8'h60, 9'h000, 2'b00));
      issue(mk(2'b01, 1'b0, 4'd0, 9'h0C0, 4'd7, 4'd4, 4'd5));
      tick();
      alu_ps_az = 1; alu_ps_av = 1; alu_ps_compd = 1;
      chk("t3_cmp_cuen", ps_xb_w_cuEn, 0);
      chk("t3_cmp_bc_ready", bc_ready, 1);
      tick();
      clr_flags();
      chk("t3_astat", astat, 12'h709);
      astat_clr = 1;
      tick();
      astat_clr = 0;
      chk("t3_clr", astat, 12'h109);

      // Compare with av=1 and a simultaneous clear: the set wins
      iss_q.push_back(iv(3'b001, 4'd4, 4'd5, 8'h60, 9'h000, 2'b00));
      issue(mk(2'b01, 1'b0, 4'd0, 9'h0C0, 4'd7, 4'd4, 4'd5));
      tick();
      alu_ps_av = 1;
      astat_clr = 1;
      tick();
      clr_flags();
      astat_clr = 0;
      chk("t3_set_wins", astat, 12'h208);

      // Bus write blocked by a MUL writeback, then accepted
      iss_q.push_back(iv(3'b010, 4'd0, 4'd0, 8'h00, 9'h000, 2'b00));
      wb_q.push_back(wv(3'b010, 4'd2, 1'b0));
      wb_q.push_back(wv(3'b000, 4'd9, 1'b1));
      issue(mk(2'b10, 1'b0, 4'd0, 9'h000, 4'd2, 4'd0, 4'd0));
      tick();
      bc_wr_en  = 1;
      bc_wr_add = 4'd9;
      #1;
      chk("t4_busy_ready", bc_ready, 0);
      chk("t4_busy_bcen", ps_xb_w_bcEn, 0);
      tick();
      chk("t4_free_ready", bc_ready, 1);
      chk("t4_free_bcen", ps_xb_w_bcEn, 1);
      chk("t4_free_wadd", ps_xb_wadd, 4'd9);
      tick();
      bc_wr_en  = 0;
      bc_wr_add = 0;

      // Stall three cycles with a SHF in W
      iss_q.push_back(iv(3'b100, 4'hB, 4'hC, 8'h00, 9'h000, 2'b10));
      wb_q.push_back(wv(3'b100, 4'hA, 1'b0));
      issue(mk(2'b11, 1'b0, 4'd0, 9'h1F6, 4'hA, 4'hB, 4'hC));
      tick();
      stall       = 1;
      shf_ps_sv   = 1;
      instr_valid = 1;
      instr       = mk(2'b01, 1'b0, 4'd0, 9'h000, 4'd1, 4'd1, 4'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_stall_cuen", ps_xb_w_cuEn, 3'b100);
         chk("t5_stall_wadd", ps_xb_wadd, 4'hA);
         chk("t5_stall_en", {ps_shf_en, ps_mul_en, ps_alu_en}, 0);
         chk("t5_stall_astat", astat, 12'h208);
      end
      stall       = 0;
      instr_valid = 0;
      instr       = 0;
      shf_ps_sv   = 0;
      shf_ps_sz   = 1;
      tick();
      clr_flags();
      chk("t5_astat", astat, 12'h288);
      chk("t5_once_cuen", ps_xb_w_cuEn, 0);
      chk("t5_no_capture_en", {ps_shf_en, ps_mul_en, ps_alu_en}, 0);

      // Asynchronous reset while an ALU sits in W
      iss_q.push_back(iv(3'b001, 4'd1, 4'd1, 8'h00, 9'h000, 2'b00));
      issue(mk(2'b01, 1'b0, 4'd0, 9'h000, 4'd3, 4'd1, 4'd1));
      tick();
      chk("t6_w_cuen", ps_xb_w_cuEn, 3'b001);
      #2;
      reset = 0;
      #1;
      chk("t6_rst_cuen", ps_xb_w_cuEn, 0);
      chk("t6_rst_wadd", ps_xb_wadd, 0);
      chk("t6_rst_astat", astat, 12'h000);
      chk("t6_rst_ready", bc_ready, 1);
      tick();
      tick();
      reset = 1;
      tick();
      tick();
      chk("t6_post_astat", astat, 12'h000);
      chk("t6_post_cuen", ps_xb_w_cuEn, 0);
      chk("t6_post_en", {ps_shf_en, ps_mul_en, ps_alu_en}, 0);

      chk("iss_q_drained", iss_q.size(), 0);
      chk("wb_q_drained", wb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cu_issue.md
Name: cu_issue

Overview:
- Program-sequencer-side issue stage for the compute unit.
- Decodes one 32-bit compute instruction per cycle into the crossbar, ALU, multiplier and shifter control signals the compute unit consumes.
- Sequences register-file writeback one cycle later and captures the flags the compute unit returns into a status register (ASTAT) with sticky bits.
- Evaluates the instruction condition code against ASTAT so that conditional compute operations are squashed.

Parameters:
- ADDRESS_WIDTH, 4, register-file address width; fixed operand fields require exactly 4.
- SIGNAL_WIDTH, 3, width of ps_xb_w_cuEn; one-hot, bit0 ALU, bit1 MUL, bit2 SHF.
- INSTR_WIDTH, 32, compute instruction width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  global stall; all state holds.
- instr_valid  in  1  instr is a compute instruction to issue this cycle.
- instr  in  32  [31:30] unit (00 nop, 01 ALU, 10 MUL, 11 SHF); [29] cond_en; [28:25] cond; [24:16] op; [15:12] reserved; [11:8] Rn; [7:4] Rx; [3:0] Ry.
- astat_clr  in  1  clears sticky bits.
- bc_wr_en  in  1  bus-side register-file write request.
- bc_wr_add  in  4  its address.
- bc_ready  out  1  bus write accepted this cycle.
- ps_xb_raddx, ps_xb_raddy  out  4  read addresses.
- ps_xb_wadd  out  4  write address.
- ps_xb_w_cuEn  out  3  compute writeback select.
- ps_xb_w_bcEn  out  1  bus writeback.
- ps_alu_en, ps_alu_log, ps_alu_hc[1:0], ps_alu_sc[2:0], ps_alu_sat, ps_alu_ci  out  ALU controls.
- ps_mul_en, ps_mul_otreg, ps_mul_dtsts[3:0], ps_mul_cls[1:0], ps_mul_sc[1:0]  out  multiplier controls.
- ps_shf_en, ps_shf_cls[1:0]  out  shifter controls.
- alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av, alu_ps_compd, mul_ps_mv, mul_ps_mn, shf_ps_sv, shf_ps_sz  in  1 each  compute-unit flags.
- astat  out  12  {svs, mvs, avs, compd, sz, sv, mn, mv, av, ac, an, az}.

Behaviour:
- Reset:
  - All outputs and registers go to 0; bc_ready is 1.
  - Reset mid-operation discards both stages with no writeback.
- Stage I (issue):
  - Captures instr when instr_valid & !stall.
  - Drives read addresses and unit controls from the registered instruction, one cycle after capture.
  - Exactly one unit enable is high; none for nop or a squashed instruction.
- Op mapping:
  - ALU: log=op[8], hc=op[7:6], sc=op[5:3], sat=op[2], ci=op[1].
  - MUL: otreg=op[8], dtsts=op[7:4], cls=op[3:2], sc=op[1:0].
  - SHF: cls=op[1:0].
- Stage W (writeback):
  - Entered the cycle after Stage I.
  - ps_xb_wadd=Rn; ps_xb_w_cuEn = one-hot of the unit.
  - Exception: ALU with hc=2'b11 is a compare; no writeback, cuEn=0.
- Flag capture (same W cycle, when !stall):
  - ALU op: az, an, ac, av, compd update.
  - MUL op: mv, mn update.
  - SHF op: sv, sz update.
  - Flags of non-executing units are held.
  - Sticky avs|=av, mvs|=mv, svs|=sv.
  - astat_clr zeros the sticky bits; a set in the same cycle wins over the clear.
- Conditions:
  - Evaluated at Stage I entry.
  - Codes: 0 EQ az; 1 NE !az; 2 LT an; 3 GE !an; 4 AC; 5 !AC; 6 AV; 7 MV; 8 MN; 9 SV; 10 SZ; 11 COMPD; 12-14 false; 15 true.
  - cond_en=0 means always true.
  - Evaluated against the bypassed next-state ASTAT, so back-to-back flag dependence needs no bubble.
  - A false condition turns the instruction into a nop in both stages.
- Bus writes:
  - bc_ready = !(W valid with cuEn!=0).
  - When bc_wr_en & bc_ready: ps_xb_w_bcEn=1 and ps_xb_wadd=bc_wr_add, combinationally.
  - Otherwise bcEn=0 and the requester retries.
- Stall:
  - Both stage registers, ASTAT and the outputs hold their values.
  - Flags are not sampled.
  - instr is not captured.
- Throughput: one instruction per cycle; issue-to-writeback latency 2 cycles from capture.

Decomposition:
- Shared package cu_pkg holds:
  - unit codes;
  - cond codes;
  - instruction field bit positions;
  - ASTAT bit indices;
  - cuEn one-hot constants.
- One sub-module, cu_cond_eval: combinational condition evaluation from the bypassed ASTAT and the 4-bit cond.

Test Plan:
- ALU add 0x0_4_1_2 (unit 01, op 0, Rn=4, Rx=1, Ry=2) issued with alu_ps_az=1 returned in W:
  - raddx=1, raddy=2 after 1 cycle;
  - then cuEn=3'b001, wadd=4;
  - astat[0]=1.
- MUL followed by a conditional ALU with cond=7 (MV):
  - mul_ps_mv=1 in W → the ALU issues; mvs=1.
  - Repeat with mv=0 → the ALU is squashed: no enables, cuEn=0.
- Compare (ALU hc=11) → cuEn stays 0, compd captured; with astat_clr after av=1, avs clears while av remains 1.
- bc_wr_en with add=9:
  - during a W-stage MUL writeback → bc_ready=0, bcEn=0;
  - next cycle → bcEn=1, wadd=9.
- stall high for 3 cycles mid-pipeline → all outputs frozen, flag pulses ignored; after release, the writeback completes exactly once.
- reset low asserted asynchronously mid-W → outputs 0 immediately; after release, astat=0 and no writeback occurs.
